// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad row scanner with frame debounce and hex entry shift register
module keypad_scan #(
    parameter int SCAN_BITS = 9,
    parameter int DEB_CNT   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  key_col,
    input  logic        clr,
    output logic [3:0]  key_row,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [31:0] entry
);

    typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, RELEASE_DEB} state_t;

    logic [3:0]           col_s1_q, col_s2_q;
    logic [SCAN_BITS-1:0] div_q;
    logic [1:0]           row_q;
    logic [15:0]          snap_q, snap_d;
    state_t               state_q;
    logic [3:0]           cand_q, cnt_q;
    logic [3:0]           key_code_q;
    logic                 key_valid_q, key_held_q;
    logic [31:0]          entry_q;

    logic                 dwell_end, eval;
    logic [4:0]           n_low;
    logic [3:0]           low_idx;
    logic                 none, single;

    assign dwell_end = &div_q;
    assign eval      = dwell_end && (row_q == 2'd3);
    assign key_row   = ~(4'b0001 << row_q);

    // Snapshot including the row being sampled this cycle, so row 3 counts in its own frame.
    always_comb begin
        snap_d = snap_q;
        snap_d[{row_q, 2'b00} +: 4] = col_s2_q;
    end

    always_comb begin
        n_low   = 5'd0;
        low_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (!snap_d[i]) begin
                n_low   = n_low + 5'd1;
                low_idx = 4'(i);
            end
        end
    end

    assign none   = (n_low == 5'd0);
    assign single = (n_low == 5'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1_q <= 4'hF;
            col_s2_q <= 4'hF;
            div_q    <= '0;
            row_q    <= 2'd0;
            snap_q   <= 16'hFFFF;
        end else begin
            col_s1_q <= key_col;
            col_s2_q <= col_s1_q;
            div_q    <= div_q + SCAN_BITS'(1);
            if (dwell_end) begin
                row_q  <= row_q + 2'd1;
                snap_q <= snap_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            entry_q     <= 32'd0;
        end else begin
            key_valid_q <= 1'b0;
            if (eval) begin
                case (state_q)
                    IDLE: begin
                        if (single) begin
                            state_q <= PRESS_DEB;
                            cand_q  <= low_idx;
                            cnt_q   <= 4'd1;
                        end
                    end
                    PRESS_DEB: begin
                        if (!single) begin
                            state_q <= IDLE;
                        end else if (low_idx != cand_q) begin
                            cand_q <= low_idx;
                            cnt_q  <= 4'd1;
                        end else if (cnt_q == 4'(DEB_CNT - 1)) begin
                            state_q     <= HELD;
                            key_held_q  <= 1'b1;
                            key_valid_q <= 1'b1;
                            key_code_q  <= cand_q;
                            entry_q     <= {entry_q[27:0], cand_q};
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                    HELD: begin
                        if (none) begin
                            state_q <= RELEASE_DEB;
                            cnt_q   <= 4'd1;
                        end
                    end
                    RELEASE_DEB: begin
                        if (!none) begin
                            state_q <= HELD;
                        end else if (cnt_q == 4'(DEB_CNT - 1)) begin
                            state_q    <= IDLE;
                            key_held_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
            if (clr) begin
                entry_q <= 32'd0;
            end
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign entry     = entry_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - directed segment table, reset sequences and random frames against a run-length model
module tb_keypad_scan;

    localparam int SB = 2;
    localparam int D  = 3;

    logic        clk = 1'b0;
    logic        rst_n, clr;
    logic [3:0]  key_col, key_row, key_code;
    logic        key_valid, key_held;
    logic [31:0] entry;
    logic [15:0] mask;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    keypad_scan #(.SCAN_BITS(SB), .DEB_CNT(D)) dut (
        .clk(clk), .rst_n(rst_n), .key_col(key_col), .clr(clr),
        .key_row(key_row), .key_code(key_code), .key_valid(key_valid),
        .key_held(key_held), .entry(entry)
    );

    // Keypad model: a pressed key {r,c} pulls column c low while row r is driven low.
    always_comb begin
        key_col = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!key_row[r])
                for (int c = 0; c < 4; c++)
                    if (mask[4*r+c]) key_col[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One 16-cycle frame starting at the negedge after a frame boundary.
    task automatic run_frame(input logic [15:0] m, input int clr_cyc, input bit chk_row,
                             output int pulses, output int stray);
        logic [3:0] exp_row;
        pulses = 0;
        stray  = 0;
        mask   = m;
        if (chk_row) check("row_walk_0", {28'd0, key_row}, 32'hE);
        for (int i = 1; i <= 16; i++) begin
            if (i == clr_cyc) clr = 1'b1;
            @(posedge clk);
            #1 clr = 1'b0;
            @(negedge clk);
            if (key_valid) begin
                if (i == 16) pulses++;
                else stray++;
            end
            if (chk_row) begin
                exp_row = ~(4'b0001 << ((i / 4) % 4));
                check("row_walk", {28'd0, key_row}, {28'd0, exp_row});
            end
        end
    endtask

    // Reference: run length of identical frame classifications drives accept and release.
    int          m_cls, m_run;
    bit          m_held;
    logic [3:0]  m_code;
    logic [31:0] m_entry;

    task automatic model_reset();
        m_cls = -1; m_run = 0; m_held = 0; m_code = 4'd0; m_entry = 32'd0;
    endtask

    task automatic model_frame(input logic [15:0] m, input int clr_cyc, output int exp_pulse);
        int n, cls;
        n = $countones(m);
        cls = (n == 0) ? 16 : (n == 1) ? $clog2(m) : 17;
        if (cls == m_cls) m_run++;
        else begin m_cls = cls; m_run = 1; end
        exp_pulse = 0;
        if (clr_cyc >= 1 && clr_cyc < 16) m_entry = 32'd0;
        if (!m_held && cls < 16 && m_run == D) begin
            exp_pulse = 1;
            m_held    = 1;
            m_code    = 4'(cls);
            m_entry   = {m_entry[27:0], m_code};
        end else if (m_held && cls == 16 && m_run == D) begin
            m_held = 0;
        end
        if (clr_cyc == 16) m_entry = 32'd0;
    endtask

    typedef struct {
        logic [15:0] mask;
        int          nfr;
        int          clr_cyc;
        int          pulses;
        logic [3:0]  code;
        logic        held;
        logic [31:0] entry;
    } seg_t;

    seg_t segs[$];

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int p, s, sp, ss, ep, nhold, cc, sel;
        logic [15:0] m;
        logic [3:0] keys[4];

        // Single press of key 9, release in two steps to see key_held fall on the third frame.
        segs.push_back('{16'h0200, 20, 0, 1, 4'h9, 1'b1, 32'h9});
        segs.push_back('{16'h0000,  2, 0, 0, 4'h9, 1'b1, 32'h9});
        segs.push_back('{16'h0000,  1, 0, 0, 4'h9, 1'b0, 32'h9});
        // Bounce on key 5, then stable.
        for (int j = 0; j < 3; j++) begin
            segs.push_back('{16'h0020, 1, 0, 0, 4'h9, 1'b0, 32'h9});
            segs.push_back('{16'h0000, 1, 0, 0, 4'h9, 1'b0, 32'h9});
        end
        segs.push_back('{16'h0020, 2, 0, 0, 4'h9, 1'b0, 32'h9});
        segs.push_back('{16'h0020, 1, 0, 1, 4'h5, 1'b1, 32'h95});
        segs.push_back('{16'h0000, 3, 0, 0, 4'h5, 1'b0, 32'h95});
        segs.push_back('{16'h0000, 1, 5, 0, 4'h5, 1'b0, 32'h0});
        // Sequence 1, 2, 3, A.
        segs.push_back('{16'h0002, 3, 0, 1, 4'h1, 1'b1, 32'h1});
        segs.push_back('{16'h0000, 3, 0, 0, 4'h1, 1'b0, 32'h1});
        segs.push_back('{16'h0004, 3, 0, 1, 4'h2, 1'b1, 32'h12});
        segs.push_back('{16'h0000, 3, 0, 0, 4'h2, 1'b0, 32'h12});
        segs.push_back('{16'h0008, 3, 0, 1, 4'h3, 1'b1, 32'h123});
        segs.push_back('{16'h0000, 3, 0, 0, 4'h3, 1'b0, 32'h123});
        segs.push_back('{16'h0400, 3, 0, 1, 4'hA, 1'b1, 32'h123A});
        segs.push_back('{16'h0000, 3, 0, 0, 4'hA, 1'b0, 32'h123A});
        segs.push_back('{16'h0000, 1, 7, 0, 4'hA, 1'b0, 32'h0});
        // Keys 0 and 6 together, then key F with clr on its accept cycle.
        segs.push_back('{16'h0041, 4, 0, 0, 4'hA, 1'b0, 32'h0});
        segs.push_back('{16'h0000, 1, 0, 0, 4'hA, 1'b0, 32'h0});
        segs.push_back('{16'h8000, 2, 0, 0, 4'hA, 1'b0, 32'h0});
        segs.push_back('{16'h8000, 1, 16, 1, 4'hF, 1'b1, 32'h0});
        segs.push_back('{16'h0000, 3, 0, 0, 4'hF, 1'b0, 32'h0});

        rst_n = 1'b0; clr = 1'b0; mask = 16'h0;
        #1;
        check("rst_row",   {28'd0, key_row}, 32'hE);
        check("rst_code",  {28'd0, key_code}, 32'h0);
        check("rst_valid", {31'd0, key_valid}, 32'h0);
        check("rst_held",  {31'd0, key_held}, 32'h0);
        check("rst_entry", entry, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (segs[k]) begin
            sp = 0; ss = 0;
            for (int j = 0; j < segs[k].nfr; j++) begin
                run_frame(segs[k].mask, (j == segs[k].nfr - 1) ? segs[k].clr_cyc : 0, 1'b0, p, s);
                sp += p; ss += s;
            end
            check($sformatf("seg%0d_pulses", k), sp, segs[k].pulses);
            check($sformatf("seg%0d_stray", k), ss, 0);
            check($sformatf("seg%0d_code", k), {28'd0, key_code}, {28'd0, segs[k].code});
            check($sformatf("seg%0d_held", k), {31'd0, key_held}, {31'd0, segs[k].held});
            check($sformatf("seg%0d_entry", k), entry, segs[k].entry);
        end

        // Random frames against the reference model, from a fresh reset.
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int f = 0; f < 160; ) begin
            sel = $urandom_range(0, 99);
            if (sel < 40) m = 16'h0;
            else if (sel < 85) m = 16'h1 << $urandom_range(0, 15);
            else begin
                m = 16'h1 << $urandom_range(0, 15);
                while ($countones(m) < 2) m = m | (16'h1 << $urandom_range(0, 15));
            end
            nhold = $urandom_range(1, 5);
            for (int j = 0; j < nhold; j++) begin
                cc = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 16) : 0;
                run_frame(m, cc, 1'b0, p, s);
                model_frame(m, cc, ep);
                check($sformatf("rnd%0d_valid", f), p, ep);
                check($sformatf("rnd%0d_stray", f), s, 0);
                check($sformatf("rnd%0d_code", f), {28'd0, key_code}, {28'd0, m_code});
                check($sformatf("rnd%0d_held", f), {31'd0, key_held}, {31'd0, m_held});
                check($sformatf("rnd%0d_entry", f), entry, m_entry);
                f++;
            end
        end

        // Make sure entry is non-zero, then reset in the middle of a press debounce on key 7.
        keys[0] = 4'h1; keys[1] = 4'hC; keys[2] = 4'h0; keys[3] = 4'h0;
        for (int j = 0; j < 4; j++) run_frame(16'h0, 0, 1'b0, p, s);
        sp = 0; ss = 0;
        for (int j = 0; j < 3; j++) begin run_frame(16'h1 << keys[0], 0, 1'b0, p, s); sp += p; end
        for (int j = 0; j < 3; j++) run_frame(16'h0, 0, 1'b0, p, s);
        check("pre_entry_nonzero", {31'd0, (entry != 32'd0)}, 32'h1);
        sp = 0;
        for (int j = 0; j < 2; j++) begin run_frame(16'h0080, 0, 1'b0, p, s); sp += p + s; end
        check("prereset_pulses", sp, 0);
        for (int j = 0; j < 7; j++) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_row",   {28'd0, key_row}, 32'hE);
        check("midrst_valid", {31'd0, key_valid}, 32'h0);
        check("midrst_held",  {31'd0, key_held}, 32'h0);
        check("midrst_entry", entry, 32'h0);
        check("midrst_code",  {28'd0, key_code}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sp = 0; ss = 0;
        for (int j = 0; j < 2; j++) begin
            run_frame(16'h0080, 0, (j == 0), p, s);
            sp += p; ss += s;
        end
        check("postrst_early", sp, 0);
        run_frame(16'h0080, 0, 1'b0, p, s);
        ss += s;
        check("postrst_pulse", p, 1);
        check("postrst_stray", ss, 0);
        check("postrst_code",  {28'd0, key_code}, 32'h7);
        check("postrst_entry", entry, 32'h7);
        check("postrst_held",  {31'd0, key_held}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

4x4 matrix keypad scanner with debounce and hex-digit entry register: the input-side counterpart of the multiplexed seven-segment display driver. It drives one keypad row low at a time and samples the active-low columns. A stable single-key press yields one hex code per press. Each accepted code is shifted into a 32-bit entry word that feeds a 32-bit field of the display register bank.

## Interface
- SCAN_BITS, 9, row dwell = 2^SCAN_BITS clk cycles (same dwell as the display digit multiplex)
- DEB_CNT, 4, consecutive identical scan frames required to accept a press or a release (legal 2..15)

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- key_col  in  4  keypad columns, active-low, externally pulled up, asynchronous to clk
- clr  in  1  synchronous clear of entry
- key_row  out  4  row drive, active-low one-hot
- key_code  out  4  last accepted key, {row[1:0], col[1:0]}
- key_valid  out  1  one-cycle pulse per accepted press
- key_held  out  1  high while an accepted key is considered down
- entry  out  32  hex entry shift register

## Operation
- Reset values (asynchronous, on rst_n low):
  - key_row=4'b1110, key_code=0, key_valid=0, key_held=0, entry=0.
  - Divider=0, row index=0, FSM=IDLE, synchronizer flops=4'b1111, frame snapshot=all 1s.
- Column input: 2-flop synchronizer on key_col.
- Scan:
  - SCAN_BITS-bit divider free-runs.
  - Row index r (2 bits) increments when the divider is all ones and wraps 3->0.
  - key_row = ~(1<<r).
  - Synchronized columns for row r are sampled on the divider-all-ones cycle of that row's dwell, into snapshot bits [4r+3:4r].
- Frame evaluation, on the sample cycle with r=3:
  - Exactly one snapshot bit low -> key present, k = {r, c}.
  - No bits low -> none.
  - Two or more bits low -> multi.
- Debounce FSM, stepped once per frame evaluation:
  - IDLE: single k -> PRESS_DEB, cand=k, cnt=1. None or multi -> stay.
  - PRESS_DEB, single k==cand: cnt+1. When cnt reaches DEB_CNT -> HELD, fire accept.
  - PRESS_DEB, single k!=cand: cand=k, cnt=1.
  - PRESS_DEB, none or multi: -> IDLE.
  - HELD: none -> RELEASE_DEB, cnt=1. Single or multi -> stay (no repeat, no second code).
  - RELEASE_DEB: none -> cnt+1; when cnt reaches DEB_CNT -> IDLE. Single or multi -> HELD.
- Accept: key_code<=cand, key_valid=1 for exactly one cycle, entry<={entry[27:0], cand}.
- clr: entry<=0. clr wins over a same-cycle accept. key_code and key_valid are still updated on that cycle.
- key_held = (state==HELD || state==RELEASE_DEB), registered.
- Code mapping: raw {row, col}. Remapping to legend labels is done downstream.

## Timing
- Frame = 4*2^SCAN_BITS cycles (2048 at default).
- Column path: 2 cycles of synchronizer latency. Dwell must be >=4 cycles (SCAN_BITS>=2), so the sample sees columns settled for the current row.
- Press -> key_valid:
  - key_valid rises the cycle after the evaluation on which cnt reaches DEB_CNT.
  - A key stable before frame start is accepted after DEB_CNT frames. Worst case is DEB_CNT+1 frames.
- key_valid and entry update in the same cycle. key_held rises in that cycle too.
- key_code holds its value until the next accept.
- Release: key_held falls DEB_CNT frames after the first key-free frame.
- Async reset mid-debounce or mid-hold: all state is cleared immediately. After rst_n deassert, a still-held key needs a full DEB_CNT-frame debounce and then produces one key_valid.
- No combinational path from key_col to any output.

## Test plan
Bench parameters: SCAN_BITS=2 (16-cycle frame), DEB_CNT=3. The keypad model drives col c low when row r is driven low and key {r,c} is pressed.
- Reset: assert rst_n=0 mid-run -> key_row=1110, entry=0, key_valid=0, key_held=0 immediately; key_row walks 1110,1101,1011,0111 at 4-cycle steps.
- Single press: hold key row2/col1 for 20 frames -> exactly one key_valid pulse, key_code=9, entry=32'h00000009, key_held=1; after release, key_held=0 three frames later.
- Bounce: toggle key 5 press/release on alternating frames for 6 frames, then hold -> no key_valid during toggling; exactly one pulse after 3 stable frames, key_code=5.
- Sequence: press/release keys 1, 2, 3, A in turn -> four pulses, entry=32'h0000123A; then clr -> entry=0.
- Multi-key and clr priority:
  - Press keys 0 and 6 together from IDLE -> no key_valid.
  - Assert clr on the accept cycle of key F -> entry=0, key_code=F.
- Reset during PRESS_DEB with the key kept held -> no pulse before reset; exactly one pulse, DEB_CNT frames after rst_n deasserts.
